cpu_acc_mmio: RTL

CPU_ACC_MMIO -- requirements
Module: cpu_acc_mmio

---
 rtl/cpu_acc_mmio.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/cpu_acc_mmio.sv
// cpu_acc_mmio: memory-mapped bridge between a CPU data port and a streaming
// accelerator. A 4-word register window at MMIO_BASE exposes CTRL, STATUS,
// DATA_IN (push to input FIFO) and DATA_OUT (pop from output FIFO); every
// other address is forwarded untouched to data memory.
// Ports:
//   clk, rst                        clock, async active-high reset
//   dmem_ren/dmem_wren, data_addr,
//   data_to_mem, data_to_cpu,
//   cpu_stall                       CPU data-side request/response
//   mem_ren/mem_wren, mem_rdata     forwarded data-memory port
//   acc_in_*                        input stream to accelerator (valid/ready)
//   acc_out_*                       result stream from accelerator (valid/ready)
//   acc_start, acc_busy, acc_done   accelerator control handshake
module cpu_acc_mmio #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [15:0] MMIO_BASE  = 16'hFF00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dmem_ren,
  input  logic        dmem_wren,
  input  logic [15:0] data_addr,
  input  logic [15:0] data_to_mem,
  output logic [15:0] data_to_cpu,
  output logic        cpu_stall,
  output logic        mem_ren,
  output logic        mem_wren,
  input  logic [15:0] mem_rdata,
  output logic [15:0] acc_in_data,
  output logic        acc_in_valid,
  input  logic        acc_in_ready,
  input  logic [15:0] acc_out_data,
  input  logic        acc_out_valid,
  output logic        acc_out_ready,
  output logic        acc_start,
  input  logic        acc_busy,
  input  logic        acc_done
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] OFF_CTRL     = 2'd0;
  localparam logic [1:0] OFF_STATUS   = 2'd1;
  localparam logic [1:0] OFF_DATA_IN  = 2'd2;
  localparam logic [1:0] OFF_DATA_OUT = 2'd3;

  logic [15:0] in_mem  [FIFO_DEPTH];
  logic [15:0] out_mem [FIFO_DEPTH];

  logic [PTR_W-1:0] in_wr_ptr_q, in_wr_ptr_d, in_rd_ptr_q, in_rd_ptr_d;
  logic [PTR_W-1:0] out_wr_ptr_q, out_wr_ptr_d, out_rd_ptr_q, out_rd_ptr_d;
  logic [CNT_W-1:0] in_count_q, in_count_d, out_count_q, out_count_d;
  logic             done_q, done_d;
  logic             acc_start_q, acc_start_d;

  logic       hit, rd_req, wr_req;
  logic [1:0] offset;
  logic       ctrl_wr, status_rd, din_wr, dout_rd, flush;
  logic       in_full, in_empty, out_full, out_empty;
  logic       cpu_push_in, acc_pop_in, acc_push_out, cpu_pop_out;
  logic [15:0] status_word;

  // Address decode and access qualification; both strobes high is no access.
  always_comb begin
    hit       = (data_addr[15:2] == MMIO_BASE[15:2]);
    offset    = data_addr[1:0];
    rd_req    = dmem_ren & ~dmem_wren;
    wr_req    = dmem_wren & ~dmem_ren;
    ctrl_wr   = hit & wr_req & (offset == OFF_CTRL);
    status_rd = hit & rd_req & (offset == OFF_STATUS);
    din_wr    = hit & wr_req & (offset == OFF_DATA_IN);
    dout_rd   = hit & rd_req & (offset == OFF_DATA_OUT);
    flush     = ctrl_wr & data_to_mem[1];
  end

  // FIFO flags come from registered counts only, so a same-cycle drain never
  // lets a push into a full FIFO through.
  always_comb begin
    in_full      = (in_count_q == CNT_FULL);
    in_empty     = (in_count_q == '0);
    out_full     = (out_count_q == CNT_FULL);
    out_empty    = (out_count_q == '0);
    cpu_push_in  = din_wr & ~in_full;
    cpu_pop_out  = dout_rd & ~out_empty;
    acc_pop_in   = ~in_empty & acc_in_ready;
    acc_push_out = ~out_full & acc_out_valid;
  end

  // CPU-side combinational responses; reset drops the stall immediately.
  always_comb begin
    status_word = {8'(out_count_q), done_q, acc_busy, in_full, out_empty, 4'b0000};
    mem_ren     = dmem_ren & ~hit;
    mem_wren    = dmem_wren & ~hit;
    cpu_stall   = ~rst & ((din_wr & in_full) | (dout_rd & out_empty));
    data_to_cpu = mem_rdata;
    if (hit) begin
      data_to_cpu = 16'h0000;
      if (rd_req) begin
        case (offset)
          OFF_STATUS:   data_to_cpu = status_word;
          OFF_DATA_OUT: data_to_cpu = out_mem[out_rd_ptr_q];
          default:      data_to_cpu = 16'h0000;
        endcase
      end
    end
  end

  always_comb begin
    acc_in_valid  = ~in_empty;
    acc_in_data   = in_mem[in_rd_ptr_q];
    acc_out_ready = ~out_full;
    acc_start     = acc_start_q;
  end

  // Next-state: pointers/counts, sticky done, start pulse. Flush overrides.
  always_comb begin
    in_wr_ptr_d  = in_wr_ptr_q;
    in_rd_ptr_d  = in_rd_ptr_q;
    in_count_d   = in_count_q;
    out_wr_ptr_d = out_wr_ptr_q;
    out_rd_ptr_d = out_rd_ptr_q;
    out_count_d  = out_count_q;
    done_d       = acc_done | (done_q & ~status_rd);
    acc_start_d  = ctrl_wr & data_to_mem[0] & ~acc_busy;
    if (flush) begin
      in_wr_ptr_d  = '0;
      in_rd_ptr_d  = '0;
      in_count_d   = '0;
      out_wr_ptr_d = '0;
      out_rd_ptr_d = '0;
      out_count_d  = '0;
    end else begin
      if (cpu_push_in)  in_wr_ptr_d  = in_wr_ptr_q + PTR_W'(1);
      if (acc_pop_in)   in_rd_ptr_d  = in_rd_ptr_q + PTR_W'(1);
      if (acc_push_out) out_wr_ptr_d = out_wr_ptr_q + PTR_W'(1);
      if (cpu_pop_out)  out_rd_ptr_d = out_rd_ptr_q + PTR_W'(1);
      case ({cpu_push_in, acc_pop_in})
        2'b10:   in_count_d = in_count_q + CNT_W'(1);
        2'b01:   in_count_d = in_count_q - CNT_W'(1);
        default: in_count_d = in_count_q;
      endcase
      case ({acc_push_out, cpu_pop_out})
        2'b10:   out_count_d = out_count_q + CNT_W'(1);
        2'b01:   out_count_d = out_count_q - CNT_W'(1);
        default: out_count_d = out_count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_wr_ptr_q  <= '0;
      in_rd_ptr_q  <= '0;
      in_count_q   <= '0;
      out_wr_ptr_q <= '0;
      out_rd_ptr_q <= '0;
      out_count_q  <= '0;
      done_q       <= 1'b0;
      acc_start_q  <= 1'b0;
    end else begin
      in_wr_ptr_q  <= in_wr_ptr_d;
      in_rd_ptr_q  <= in_rd_ptr_d;
      in_count_q   <= in_count_d;
      out_wr_ptr_q <= out_wr_ptr_d;
      out_rd_ptr_q <= out_rd_ptr_d;
      out_count_q  <= out_count_d;
      done_q       <= done_d;
      acc_start_q  <= acc_start_d;
    end
  end

  // FIFO storage needs no reset; contents are only visible through counts.
  always_ff @(posedge clk) begin
    if (cpu_push_in & ~flush & ~rst)  in_mem[in_wr_ptr_q]   <= data_to_mem;
    if (acc_push_out & ~flush & ~rst) out_mem[out_wr_ptr_q] <= acc_out_data;
  end

endmodule
